// File: rtl/nn_pkg.sv
// Shared constants and types for the nn datapath stages.
package nn_pkg;

  // Signed fixed-point format: N-bit words with FRAC fractional bits.
  localparam int unsigned N    = 32;
  localparam int unsigned FRAC = 11;
  localparam int          ONE  = 1 << FRAC;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StFinal,
    StOut
  } state_e;

  typedef logic signed [N-1:0] word_t;

endpackage

// File: rtl/fx_round_sat.sv
// Rounds a wide accumulator back to N-bit fixed point, saturates, and
// optionally applies ReLU. Purely combinational.
module fx_round_sat #(
  parameter int unsigned N     = nn_pkg::N,
  parameter int unsigned FRAC  = nn_pkg::FRAC,
  parameter int unsigned ACC_W = 2 * nn_pkg::N + 9
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic                    relu_en,
  output logic signed [N-1:0]     out,
  output logic                    sat
);

  // Half an LSB of the output format, so the shift rounds half toward +inf.
  localparam logic signed [ACC_W-1:0] Half = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] MaxV = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MinV = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

  logic signed [ACC_W-1:0] rounded;
  logic signed [ACC_W-1:0] scaled;
  logic signed [N-1:0]     res;

  // Round, clamp to the N-bit signed range, then ReLU on the clamped value.
  always_comb begin
    rounded = acc + Half;
    scaled  = rounded >>> FRAC;
    sat     = 1'b0;
    res     = scaled[N-1:0];
    if (scaled > MaxV) begin
      res = {1'b0, {(N-1){1'b1}}};
      sat = 1'b1;
    end else if (scaled < MinV) begin
      res = {1'b1, {(N-1){1'b0}}};
      sat = 1'b1;
    end
    // sat reports the clamp even when ReLU then zeroes the result.
    if (relu_en && res[N-1]) begin
      res = '0;
    end
    out = res;
  end

endmodule

// File: rtl/dense_neuron_mac.sv
// Single-neuron multiply-accumulate stage: bias + sum(x*w), rounded and
// saturated to N-bit fixed point, with optional ReLU.
module dense_neuron_mac #(
  parameter int unsigned N     = nn_pkg::N,
  parameter int unsigned FRAC  = nn_pkg::FRAC,
  parameter int unsigned LEN_W = 9,
  parameter int unsigned ACC_W = 2 * N + LEN_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic        [LEN_W-1:0] len,
  input  logic signed [N-1:0]     bias,
  input  logic                    relu_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [N-1:0]     x,
  input  logic signed [N-1:0]     w,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [N-1:0]     out,
  output logic                    sat,
  output logic                    busy,
  output logic                    done
);

  import nn_pkg::*;

  state_e                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic        [LEN_W-1:0] count_q;
  logic                    relu_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    busy_q;
  logic                    done_q;
  logic signed [N-1:0]     out_q;
  logic                    sat_q;

  logic signed [2*N-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_init;
  logic signed [N-1:0]     rs_out;
  logic                    rs_sat;

  assign prod     = x * w;
  assign prod_ext = $signed({{(ACC_W-2*N){prod[2*N-1]}}, prod});
  // Bias is aligned to the product scale (2*FRAC fractional bits).
  assign acc_init = $signed({{(ACC_W-N){bias[N-1]}}, bias}) <<< FRAC;

  fx_round_sat #(
    .N     (N),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_round_sat (
    .acc     (acc_q),
    .relu_en (relu_q),
    .out     (rs_out),
    .sat     (rs_sat)
  );

  // Control FSM with accumulator, beat counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      count_q     <= '0;
      relu_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_q       <= '0;
      sat_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            acc_q   <= acc_init;
            count_q <= len;
            relu_q  <= relu_en;
            busy_q  <= 1'b1;
            if (len != '0) begin
              state_q    <= StAccum;
              in_ready_q <= 1'b1;
            end else begin
              state_q <= StFinal;
            end
          end
        end
        StAccum: begin
          if (in_valid && in_ready_q) begin
            acc_q   <= acc_q + prod_ext;
            count_q <= count_q - LEN_W'(1);
            if (count_q == LEN_W'(1)) begin
              state_q    <= StFinal;
              in_ready_q <= 1'b0;
            end
          end
        end
        StFinal: begin
          out_q       <= rs_out;
          sat_q       <= rs_sat;
          out_valid_q <= 1'b1;
          state_q     <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign sat       = sat_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dense_neuron_mac.sv
// Self-checking bench for dense_neuron_mac: directed cases plus randomized
// jobs against a plain-arithmetic reference model.
module tb_dense_neuron_mac;

  import nn_pkg::*;

  localparam int unsigned LEN_W = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  word_t             bias;
  logic              relu_en;
  logic              in_valid;
  logic              in_ready;
  word_t             x;
  word_t             w;
  logic              out_valid;
  logic              out_ready;
  word_t             dout;
  logic              sat;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;

  word_t xs[$];
  word_t ws[$];

  always #5 clk = ~clk;

  dense_neuron_mac #(
    .N     (N),
    .FRAC  (FRAC),
    .LEN_W (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .bias      (bias),
    .relu_en   (relu_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .w         (w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .sat       (sat),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact wide arithmetic, floor((acc + half) / 2^FRAC), clamp, ReLU.
  function automatic void model(input int n, input word_t b, input bit relu,
                                output word_t eo, output bit es);
    logic signed [127:0] acc;
    logic signed [127:0] r;
    acc = 128'(b) * ONE;
    for (int i = 0; i < n; i++) acc += 128'(xs[i]) * 128'(ws[i]);
    r  = (acc + 128'sd1024) >>> FRAC;
    es = 1'b0;
    if (r > 128'sd2147483647) begin
      r  = 128'sd2147483647;
      es = 1'b1;
    end else if (r < -128'sd2147483648) begin
      r  = -128'sd2147483648;
      es = 1'b1;
    end
    if (relu && r < 0) r = 0;
    eo = word_t'(r);
  endfunction

  // gap < 0 means a random 0..2 idle cycles before each beat.
  task automatic run_job(input string tag, input int n, input word_t b, input bit relu,
                         input int gap, input int stall,
                         output word_t got_out, output logic got_sat);
    word_t eo;
    bit    es;
    int    g;
    model(n, b, relu, eo, es);
    start   = 1'b1;
    len     = LEN_W'(n);
    bias    = b;
    relu_en = relu;
    tick();
    start   = 1'b0;
    bias    = word_t'($urandom);
    relu_en = ~relu;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_in_ready"}, in_ready, (n != 0));
    for (int i = 0; i < n; i++) begin
      g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0;
        x = word_t'($urandom);
        w = word_t'($urandom);
        tick();
      end
      in_valid = 1'b1;
      x = xs[i];
      w = ws[i];
      tick();
    end
    in_valid = 1'b0;
    check({tag, "_final_valid"}, out_valid, 0);
    check({tag, "_final_ready"}, in_ready, 0);
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_out"}, dout, eo);
    check({tag, "_sat"}, sat, es);
    for (int s = 0; s < stall; s++) begin
      start = s[0];
      len   = LEN_W'(1);
      tick();
      check({tag, "_stall_valid"}, out_valid, 1);
      check({tag, "_stall_out"}, dout, eo);
      check({tag, "_stall_ready"}, in_ready, 0);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_post_valid"}, out_valid, 0);
    check({tag, "_post_busy"}, busy, 0);
    check({tag, "_hold_out"}, dout, eo);
    got_out = dout;
    got_sat = sat;
    tick();
    check({tag, "_done_clr"}, done, 0);
  endtask

  initial begin
    word_t o;
    logic  s;
    int    n;

    rst = 1'b0; start = 1'b0; len = '0; bias = '0; relu_en = 1'b0;
    in_valid = 1'b0; x = '0; w = '0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out", dout, 0);
    check("rst_sat", sat, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    xs = '{2048}; ws = '{2048};
    run_job("t1", 1, 0, 1'b0, 0, 0, o, s);
    check("t1_const_out", o, 2048);
    check("t1_const_sat", s, 0);

    xs = '{2048, 1024, -2048}; ws = '{1024, 2048, 512};
    run_job("t2", 3, 2048, 1'b0, 2, 0, o, s);
    check("t2_const_out", o, 3584);

    xs = '{-2048}; ws = '{2048};
    run_job("t3_relu", 1, 0, 1'b1, 0, 0, o, s);
    check("t3_relu_out", o, 0);
    run_job("t3_norelu", 1, 0, 1'b0, 0, 0, o, s);
    check("t3_norelu_out", o, -2048);

    xs = '{3}; ws = '{1024};
    run_job("t3_round", 1, 0, 1'b0, 0, 0, o, s);
    check("t3_round_out", o, 2);

    xs = '{32'sh7fffffff, 32'sh7fffffff}; ws = '{32'sh7fffffff, 32'sh7fffffff};
    run_job("t4_pos", 2, 0, 1'b0, 0, 0, o, s);
    check("t4_pos_out", o, 2147483647);
    check("t4_pos_sat", s, 1);
    ws = '{-32'sh7fffffff, -32'sh7fffffff};
    run_job("t4_neg", 2, 0, 1'b0, 0, 0, o, s);
    check("t4_neg_out", o, -64'sd2147483648);
    check("t4_neg_sat", s, 1);

    xs = '{4096}; ws = '{-1536};
    run_job("t5_bp", 1, 100, 1'b0, 0, 5, o, s);

    xs.delete(); ws.delete();
    run_job("t6_len0", 0, -1024, 1'b0, 0, 0, o, s);
    check("t6_len0_out", o, -1024);

    // Abort a job mid-accumulation with an asynchronous reset.
    start = 1'b1; len = LEN_W'(4); bias = 7; relu_en = 1'b0;
    tick();
    start = 1'b0;
    in_valid = 1'b1; x = 5; w = 9;
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_out", dout, 0);
    check("abort_sat", sat, 0);
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_done", done, 0);
      check("abort_no_valid", out_valid, 0);
    end
    xs = '{1024}; ws = '{4096};
    run_job("t6_fresh", 1, 0, 1'b0, 0, 0, o, s);
    check("t6_fresh_out", o, 2048);

    // Randomized jobs.
    for (int j = 0; j < 40; j++) begin
      word_t b;
      bit    big;
      n   = (j % 8 == 7) ? int'($urandom_range(24, 1)) : int'($urandom_range(6, 0));
      big = ($urandom_range(3, 0) == 0);
      xs.delete(); ws.delete();
      for (int i = 0; i < n; i++) begin
        if (big) begin
          xs.push_back(word_t'($urandom));
          ws.push_back(word_t'($urandom));
        end else begin
          xs.push_back(word_t'(int'($urandom_range(16383, 0)) - 8192));
          ws.push_back(word_t'(int'($urandom_range(16383, 0)) - 8192));
        end
      end
      b = big ? word_t'($urandom) : word_t'(int'($urandom_range(65535, 0)) - 32768);
      run_job($sformatf("rnd%0d", j), n, b, 1'(j % 3 == 0), -1,
              int'($urandom_range(3, 0)), o, s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
